tile_drop_engine: RTL and testbench

//   Game-state producer for the column-drop 2048 board. Takes debounced button pulses,

---
 rtl/tile_drop_engine.sv | 176 +++++++++++++++++
 tb/tb_tile_drop_engine.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/tile_drop_engine.sv
// Column-drop 2048 game engine: cursor handling, tile placement, vertical merge
// resolution, win/lose detection and preview-tile generation for the renderer.
module tile_drop_engine #(
  parameter int unsigned WIN_EXP   = 11,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        mastClk,
  input  logic        rst,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic        btn_drop,
  output logic [79:0] board_flat,
  output logic [15:0] score,
  output logic        game_over,
  output logic        game_won,
  output logic [1:0]  cursor_col,
  output logic [4:0]  spawn_val,
  output logic        display_ready
);

  localparam int unsigned EXP_W   = 5;
  localparam int unsigned CELLS   = 16;
  localparam int unsigned SCORE_W = 16;
  localparam logic [EXP_W-1:0] WIN_V   = EXP_W'(WIN_EXP);
  localparam logic [EXP_W-1:0] EXP_MAX = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLACE,
    S_MERGE,
    S_CHECK,
    S_OVER,
    S_WON
  } state_t;

  state_t                        state_q, state_d;
  logic [CELLS-1:0][EXP_W-1:0]   board_q, board_d;
  logic [SCORE_W-1:0]            score_q, score_d;
  logic [1:0]                    cursor_q, cursor_d;
  logic [EXP_W-1:0]              spawn_q, spawn_d;
  logic [1:0]                    col_q, col_d;
  logic [1:0]                    land_q, land_d;
  logic [15:0]                   lfsr_q, lfsr_d;

  logic [1:0]         place_row;
  logic [3:0]         land_idx;
  logic [3:0]         below_idx;
  logic [EXP_W-1:0]   land_val;
  logic               merge_ok;
  logic [5:0]         shift_amt;
  logic [SCORE_W:0]   addend;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_sat;
  logic               any_win;
  logic               top_full;

  // Lowest empty row in the latched column (row 0 is known empty here).
  always_comb begin
    place_row = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (board_q[{2'(i), col_q}] == '0) place_row = 2'(i);
    end
  end

  // Merge test for the tile currently being resolved, plus saturating score.
  always_comb begin
    land_idx  = {land_q, col_q};
    below_idx = {land_q + 2'd1, col_q};
    land_val  = board_q[land_idx];
    merge_ok  = (land_q != 2'd3) && (board_q[below_idx] == land_val) &&
                (land_val != EXP_MAX);
    shift_amt = 6'(land_val) + 6'd1;
    addend    = (shift_amt >= 6'd16) ? 17'h10000 : (17'd1 << shift_amt);
    score_sum = {1'b0, score_q} + addend;
    score_sat = score_sum[SCORE_W] ? 16'hFFFF : score_sum[SCORE_W-1:0];
  end

  // End-of-turn board status.
  always_comb begin
    any_win  = 1'b0;
    top_full = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (board_q[4'(i)] >= WIN_V) any_win = 1'b1;
    end
    for (int c = 0; c < 4; c++) begin
      if (board_q[4'(c)] == '0) top_full = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    score_d  = score_q;
    cursor_d = cursor_q;
    spawn_d  = spawn_q;
    col_d    = col_q;
    land_d   = land_q;
    lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    case (state_q)
      S_IDLE: begin
        if (btn_drop) begin
          if (board_q[{2'd0, cursor_q}] != '0) begin
            state_d = S_OVER;
          end else begin
            col_d   = cursor_q;
            state_d = S_PLACE;
          end
        end else if (btn_l && !btn_r) begin
          if (cursor_q != 2'd0) cursor_d = cursor_q - 2'd1;
        end else if (btn_r && !btn_l) begin
          if (cursor_q != 2'd3) cursor_d = cursor_q + 2'd1;
        end
      end
      S_PLACE: begin
        board_d[{place_row, col_q}] = spawn_q;
        land_d  = place_row;
        state_d = S_MERGE;
      end
      S_MERGE: begin
        if (merge_ok) begin
          board_d[below_idx] = land_val + 5'd1;
          board_d[land_idx]  = '0;
          score_d            = score_sat;
          land_d             = land_q + 2'd1;
        end else begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (any_win) begin
          state_d = S_WON;
        end else if (top_full) begin
          state_d = S_OVER;
        end else begin
          spawn_d = (lfsr_q[1:0] == 2'b00) ? 5'd2 : 5'd1;
          state_d = S_IDLE;
        end
      end
      S_OVER:  state_d = S_OVER;
      S_WON:   state_d = S_WON;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge mastClk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      board_q  <= '0;
      score_q  <= '0;
      cursor_q <= 2'd0;
      spawn_q  <= 5'd1;
      col_q    <= 2'd0;
      land_q   <= 2'd0;
      lfsr_q   <= LFSR_SEED;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      score_q  <= score_d;
      cursor_q <= cursor_d;
      spawn_q  <= spawn_d;
      col_q    <= col_d;
      land_q   <= land_d;
      lfsr_q   <= lfsr_d;
    end
  end

  assign board_flat    = board_q;
  assign score         = score_q;
  assign cursor_col    = cursor_q;
  assign spawn_val     = spawn_q;
  assign game_over     = (state_q == S_OVER);
  assign game_won      = (state_q == S_WON);
  assign display_ready = (state_q == S_IDLE) || (state_q == S_OVER) || (state_q == S_WON);

endmodule

// File: tb/tb_tile_drop_engine.sv
// Bench for tile_drop_engine: two instances (default win and WIN_EXP=3) checked each
// cycle against a turn-level game model, plus directed literal checks.
module tb_tile_drop_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_l = 1'b0, btn_r = 1'b0, btn_drop = 1'b0;
  logic [79:0] board_flat [2];
  logic [15:0] score [2];
  logic        game_over [2], game_won [2], display_ready [2];
  logic [1:0]  cursor_col [2];
  logic [4:0]  spawn_val [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tile_drop_engine #(.WIN_EXP(11), .LFSR_SEED(16'hACE1)) d0 (
    .mastClk(clk), .rst(rst), .btn_l(btn_l), .btn_r(btn_r), .btn_drop(btn_drop),
    .board_flat(board_flat[0]), .score(score[0]), .game_over(game_over[0]),
    .game_won(game_won[0]), .cursor_col(cursor_col[0]), .spawn_val(spawn_val[0]),
    .display_ready(display_ready[0]));

  tile_drop_engine #(.WIN_EXP(3), .LFSR_SEED(16'hACE1)) d1 (
    .mastClk(clk), .rst(rst), .btn_l(btn_l), .btn_r(btn_r), .btn_drop(btn_drop),
    .board_flat(board_flat[1]), .score(score[1]), .game_over(game_over[1]),
    .game_won(game_won[1]), .cursor_col(cursor_col[1]), .spawn_val(spawn_val[1]),
    .display_ready(display_ready[1]));

  // Turn-level model: a drop is resolved in one step; busy counts the cycles the
  // engine spends before the end-of-turn evaluation takes effect.
  int  mb    [2][16];
  int  msc   [2];
  int  mcur  [2];
  int  mspn  [2];
  int  mbusy [2];
  bit  mover [2];
  bit  mwon  [2];
  int  mwin  [2] = '{11, 3};
  int  mlfsr;
  bit  chk_en = 1'b0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [79:0] model_board(input int k);
    logic [79:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) b[i*5 +: 5] = 5'(mb[k][i]);
    return b;
  endfunction

  task automatic model_step(input int k);
    int c, r, v, m;
    bit full;
    longint s;
    if (rst) begin
      for (int i = 0; i < 16; i++) mb[k][i] = 0;
      msc[k] = 0; mcur[k] = 0; mspn[k] = 1; mbusy[k] = 0;
      mover[k] = 0; mwon[k] = 0;
    end else if (mover[k] || mwon[k]) begin
      // frozen
    end else if (mbusy[k] > 0) begin
      mbusy[k]--;
      if (mbusy[k] == 0) begin
        full = 1;
        for (int i = 0; i < 16; i++) if (mb[k][i] >= mwin[k]) mwon[k] = 1;
        for (int i = 0; i < 4; i++) if (mb[k][i] == 0) full = 0;
        if (!mwon[k]) begin
          if (full) mover[k] = 1;
          else mspn[k] = ((mlfsr % 4) == 0) ? 2 : 1;
        end
      end
    end else if (btn_drop) begin
      c = mcur[k];
      if (mb[k][c] != 0) mover[k] = 1;
      else begin
        r = 3;
        while (mb[k][r*4+c] != 0) r--;
        mb[k][r*4+c] = mspn[k];
        m = 0;
        while (r < 3 && mb[k][(r+1)*4+c] == mb[k][r*4+c] && mb[k][r*4+c] < 31) begin
          v = mb[k][r*4+c];
          mb[k][(r+1)*4+c] = v + 1;
          mb[k][r*4+c] = 0;
          s = longint'(msc[k]) + (longint'(1) << (v + 1));
          msc[k] = (s > 65535) ? 65535 : int'(s);
          r++;
          m++;
        end
        mbusy[k] = 3 + m;
      end
    end else if (btn_l && !btn_r) begin
      if (mcur[k] > 0) mcur[k]--;
    end else if (btn_r && !btn_l) begin
      if (mcur[k] < 3) mcur[k]++;
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    if (rst) begin
      mlfsr  = 16'hACE1;
      chk_en = 1'b1;
    end else begin
      mlfsr = ((mlfsr >> 1) | (((mlfsr ^ (mlfsr >> 2) ^ (mlfsr >> 3) ^ (mlfsr >> 5)) & 1) << 15))
              & 16'hFFFF;
    end
  end

  // Per-cycle comparison; board/score/spawn are only meaningful while ready.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("d%0d.ready", k), 80'(display_ready[k]), 80'(mbusy[k] == 0));
        chk($sformatf("d%0d.over", k), 80'(game_over[k]), 80'(mover[k]));
        chk($sformatf("d%0d.won", k), 80'(game_won[k]), 80'(mwon[k]));
        chk($sformatf("d%0d.cursor", k), 80'(cursor_col[k]), 80'(mcur[k]));
        if (mbusy[k] == 0) begin
          chk($sformatf("d%0d.board", k), board_flat[k], model_board(k));
          chk($sformatf("d%0d.score", k), 80'(score[k]), 80'(msc[k]));
          chk($sformatf("d%0d.spawn", k), 80'(spawn_val[k]), 80'(mspn[k]));
        end
      end
    end
  end

  task automatic drive(input bit l, input bit r, input bit d);
    btn_l = l; btn_r = r; btn_drop = d;
    @(negedge clk); #1;
    btn_l = 0; btn_r = 0; btn_drop = 0;
  endtask

  task automatic lit_reset(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, ".board"}, board_flat[k], 80'd0);
      chk({tag, ".score"}, 80'(score[k]), 80'd0);
      chk({tag, ".cursor"}, 80'(cursor_col[k]), 80'd0);
      chk({tag, ".spawn"}, 80'(spawn_val[k]), 80'd1);
      chk({tag, ".ready"}, 80'(display_ready[k]), 80'd1);
      chk({tag, ".flags"}, 80'({game_over[k], game_won[k]}), 80'd0);
    end
  endtask

  initial begin
    int n;
    int p;
    int idle_end;
    logic [79:0] exp_b;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    lit_reset("reset");

    // Cursor saturation and simultaneous left/right.
    drive(1, 0, 0);
    chk("cur_left_sat", 80'(cursor_col[0]), 80'd0);
    repeat (5) drive(0, 1, 0);
    chk("cur_right_sat", 80'(cursor_col[0]), 80'd3);
    drive(1, 1, 0);
    chk("cur_both", 80'(cursor_col[0]), 80'd3);
    drive(1, 0, 0);
    chk("cur_to2", 80'(cursor_col[0]), 80'd2);

    // First drop on an empty board lands at the bottom with no merge.
    drive(0, 0, 1);
    n = 0;
    while (!display_ready[0] && n < 20) begin
      n++;
      @(negedge clk); #1;
    end
    chk("drop1.busy_cycles", 80'(n), 80'd3);
    exp_b = '0;
    exp_b[70 +: 5] = 5'd1;
    chk("drop1.board", board_flat[0], exp_b);
    chk("drop1.score", 80'(score[0]), 80'd0);

    // Second drop into the same column, then reset while it is resolving.
    drive(0, 0, 1);
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    lit_reset("midmerge_rst");

    // Randomized play; mostly narrow cursor moves so columns fill and merge.
    idle_end = 0;
    for (int cyc = 0; cyc < 12000; cyc++) begin
      p = $urandom_range(0, 999);
      if ((mover[0] || mwon[0]) && (mover[1] || mwon[1])) idle_end++;
      else idle_end = 0;
      rst      = (p < 4) || (idle_end > 6 && p < 300);
      btn_drop = ($urandom_range(0, 99) < 30);
      btn_l    = ($urandom_range(0, 99) < 15);
      btn_r    = ($urandom_range(0, 99) < 15);
      @(negedge clk); #1;
    end
    rst = 0; btn_l = 0; btn_r = 0; btn_drop = 0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
